// File: rtl/sprite_regs.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_regs
//  Purpose  : CPU register block for two 8x8 sprites. CPU writes land in
//             shadow registers and reach the display outputs at vblank_start
//             once a commit has been requested.
//  Optional : SPRITE_REGS_FRAME_CNT_EN adds a readable vblank frame counter.
//  Revision : 1.0  initial release
// ============================================================================
module sprite_regs #(
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [5:0]             address,
  input  logic [31:0]            data_in,
  input  logic [1:0]             data_write_n,
  input  logic [1:0]             data_read_n,
  output logic [31:0]            data_out,
  output logic                   data_ready,
  output logic                   user_interrupt,
  input  logic                   vblank_start,
  output logic [9:0]             spr0_x,
  output logic [9:0]             spr0_y,
  output logic [9:0]             spr1_x,
  output logic [9:0]             spr1_y,
  output logic [63:0]            spr0_bitmap,
  output logic [63:0]            spr1_bitmap,
  output logic                   spr_enable
);

  localparam logic [1:0] c_WR_BYTE = 2'b00;
  localparam logic [1:0] c_WR_HALF = 2'b01;
  localparam logic [1:0] c_IDLE    = 2'b11;
  localparam int         c_NSH     = 6;

  // Shadow words: 0 SPR0_POS, 1 SPR1_POS, 2/3 SPR0_BMP lo/hi, 4/5 SPR1_BMP lo/hi
  logic [31:0]            r_sh [0:c_NSH-1];
  logic                   r_en;
  logic                   r_irq_en;
  logic                   r_irq_st;
  logic                   r_pend;
  logic [9:0]             r_x0;
  logic [9:0]             r_y0;
  logic [9:0]             r_x1;
  logic [9:0]             r_y1;
  logic [63:0]            r_bmp0;
  logic [63:0]            r_bmp1;
  logic                   r_act_en;
  logic                   r_ready;
  logic [31:0]            r_dout;

  logic [2:0]             w_widx;
  logic                   w_wr;
  logic                   w_ctrl_wr;
  logic [31:0]            w_wdata;
  logic [31:0]            w_wmask;
  logic [31:0]            w_wbits;
  logic                   w_rd_req;
  logic [31:0]            w_rdata;
  logic [FRAME_CNT_W-1:0] w_frame;

  assign w_widx    = address[4:2];
  assign w_wr      = (data_write_n != c_IDLE) && !address[5];
  assign w_ctrl_wr = w_wr && (w_widx == 3'd6);
  assign w_wbits   = w_wdata & w_wmask;
  assign w_rd_req  = (data_read_n != c_IDLE) && !r_ready;

  // Replicate the narrow data across the word so the lane mask alone selects it
  always_comb begin
    w_wdata = data_in;
    w_wmask = 32'hFFFF_FFFF;
    case (data_write_n)
      c_WR_BYTE: begin
        w_wdata = {4{data_in[7:0]}};
        w_wmask = 32'h0000_00FF << {address[1:0], 3'b000};
      end
      c_WR_HALF: begin
        w_wdata = {2{data_in[15:0]}};
        w_wmask = 32'h0000_FFFF << {address[1], 4'b0000};
      end
      default: ;
    endcase
  end

`ifdef SPRITE_REGS_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] r_frame;

  always_ff @(posedge clk) begin
    if (!rst_n)            r_frame <= '0;
    else if (vblank_start) r_frame <= r_frame + FRAME_CNT_W'(1);
  end

  assign w_frame = r_frame;
`else
  assign w_frame = '0;
`endif

  always_comb begin
    w_rdata = '0;
    if (!address[5]) begin
      for (int i = 0; i < c_NSH; i++)
        if (w_widx == 3'(i)) w_rdata = r_sh[i];
      if (w_widx == 3'd6) w_rdata = {28'd0, r_pend, r_irq_st, r_irq_en, r_en};
      if (w_widx == 3'd7) w_rdata = 32'(w_frame);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < c_NSH; i++) r_sh[i] <= '0;
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_irq_st <= 1'b0;
      r_pend   <= 1'b0;
      r_x0     <= '0;
      r_y0     <= '0;
      r_x1     <= '0;
      r_y1     <= '0;
      r_bmp0   <= '0;
      r_bmp1   <= '0;
      r_act_en <= 1'b0;
      r_ready  <= 1'b0;
      r_dout   <= '0;
    end else begin
      for (int i = 0; i < c_NSH; i++)
        if (w_wr && (w_widx == 3'(i)))
          r_sh[i] <= (r_sh[i] & ~w_wmask) | w_wbits;

      if (w_ctrl_wr) begin
        if (w_wmask[0]) r_en     <= w_wdata[0];
        if (w_wmask[1]) r_irq_en <= w_wdata[1];
      end

      // A vblank set beats a same-cycle write-1-to-clear
      if (vblank_start && r_irq_en)     r_irq_st <= 1'b1;
      else if (w_ctrl_wr && w_wbits[2]) r_irq_st <= 1'b0;

      // A commit written during vblank stays armed for the next one
      if (w_ctrl_wr && w_wbits[3]) r_pend <= 1'b1;
      else if (vblank_start)       r_pend <= 1'b0;

      // Non-blocking reads here copy the pre-write shadow contents
      if (vblank_start && r_pend) begin
        r_x0     <= r_sh[0][9:0];
        r_y0     <= r_sh[0][25:16];
        r_x1     <= r_sh[1][9:0];
        r_y1     <= r_sh[1][25:16];
        r_bmp0   <= {r_sh[3], r_sh[2]};
        r_bmp1   <= {r_sh[5], r_sh[4]};
        r_act_en <= r_en;
      end

      r_ready <= w_rd_req;
      r_dout  <= w_rd_req ? w_rdata : 32'd0;
    end
  end

  assign data_out       = r_dout;
  assign data_ready     = r_ready;
  assign user_interrupt = r_irq_st & r_irq_en;
  assign spr0_x         = r_x0;
  assign spr0_y         = r_y0;
  assign spr1_x         = r_x1;
  assign spr1_y         = r_y1;
  assign spr0_bitmap    = r_bmp0;
  assign spr1_bitmap    = r_bmp1;
  assign spr_enable     = r_act_en;

endmodule
`default_nettype wire

// File: tb/tb_sprite_regs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_regs
//  Purpose  : Directed self-checking bench for sprite_regs (shadow/commit,
//             lane writes, irq, read strobe, reset, frame register).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sprite_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  address = '0;
  logic [31:0] data_in = '0;
  logic [1:0]  data_write_n = 2'b11;
  logic [1:0]  data_read_n = 2'b11;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;
  logic        vblank_start = 1'b0;
  logic [9:0]  spr0_x;
  logic [9:0]  spr0_y;
  logic [9:0]  spr1_x;
  logic [9:0]  spr1_y;
  logic [63:0] spr0_bitmap;
  logic [63:0] spr1_bitmap;
  logic        spr_enable;

  int errors = 0;
  int checks = 0;
  int nvb    = 0;

  always #5 clk = ~clk;

  sprite_regs #(.FRAME_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready),
    .user_interrupt(user_interrupt), .vblank_start(vblank_start),
    .spr0_x(spr0_x), .spr0_y(spr0_y), .spr1_x(spr1_x), .spr1_y(spr1_y),
    .spr0_bitmap(spr0_bitmap), .spr1_bitmap(spr1_bitmap),
    .spr_enable(spr_enable)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
    @(negedge clk);
    address = a; data_in = d; data_write_n = wn;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    address = a; data_read_n = 2'b00;
    @(negedge clk);
    data_read_n = 2'b11;
    check({tag, " ready"}, 64'(data_ready), 64'd1);
    check(tag, 64'(data_out), 64'(exp));
  endtask

  task automatic vb();
    @(negedge clk);
    vblank_start = 1'b1;
    @(negedge clk);
    vblank_start = 1'b0;
    nvb++;
  endtask

  // vblank_start in the same cycle as a word write
  task automatic vb_wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    vblank_start = 1'b1; address = a; data_in = d; data_write_n = 2'b10;
    @(negedge clk);
    vblank_start = 1'b0; data_write_n = 2'b11;
    nvb++;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst data_ready", 64'(data_ready), 64'd0);
    check("rst data_out", 64'(data_out), 64'd0);
    check("rst irq", 64'(user_interrupt), 64'd0);
    check("rst spr0_x", 64'(spr0_x), 64'd0);
    check("rst spr_enable", 64'(spr_enable), 64'd0);
    rst_n = 1'b1;

    // Shadow write without commit does not reach outputs
    wr(6'h00, 32'h0064_0032, 2'b10);
    vb();
    check("nocommit spr0_x", 64'(spr0_x), 64'd0);
    check("nocommit spr0_y", 64'(spr0_y), 64'd0);
    rd(6'h00, 32'h0064_0032, "rd pos0");

    // Commit applies at vblank
    wr(6'h18, 32'h0000_0009, 2'b10);
    vb();
    check("commit spr0_x", 64'(spr0_x), 64'd50);
    check("commit spr0_y", 64'(spr0_y), 64'd100);
    check("commit enable", 64'(spr_enable), 64'd1);
    rd(6'h18, 32'h0000_0001, "rd ctrl after commit");

    // Byte and halfword lane writes
    wr(6'h0A, 32'h5555_55AA, 2'b00);
    rd(6'h08, 32'h00AA_0000, "rd bmp0 lo byte");
    wr(6'h0E, 32'h1234_BEEF, 2'b01);
    rd(6'h0C, 32'hBEEF_0000, "rd bmp0 hi half");
    check("bmp pre-commit", spr0_bitmap, 64'd0);
    wr(6'h18, 32'h0000_0009, 2'b10);
    vb();
    check("bmp lane 23:16", 64'(spr0_bitmap[23:16]), 64'hAA);
    check("bmp full", spr0_bitmap, 64'hBEEF_0000_00AA_0000);

    // Interrupt: set, clear, set-wins-over-clear, clear
    wr(6'h18, 32'h0000_0003, 2'b10);
    vb();
    check("irq set", 64'(user_interrupt), 64'd1);
    wr(6'h18, 32'h0000_0007, 2'b10);
    check("irq w1c", 64'(user_interrupt), 64'd0);
    vb_wr(6'h18, 32'h0000_0007);
    check("irq set wins", 64'(user_interrupt), 64'd1);
    rd(6'h18, 32'h0000_0007, "rd ctrl irq");
    wr(6'h18, 32'h0000_0007, 2'b10);
    check("irq w1c alone", 64'(user_interrupt), 64'd0);

    // Commit written in the vblank cycle is deferred
    wr(6'h04, 32'h0003_0005, 2'b10);
    vb_wr(6'h18, 32'h0000_000B);
    check("late commit x1", 64'(spr1_x), 64'd0);
    check("late commit y1", 64'(spr1_y), 64'd0);
    rd(6'h18, 32'h0000_000F, "rd ctrl pending");
    vb();
    check("deferred x1", 64'(spr1_x), 64'd5);
    check("deferred y1", 64'(spr1_y), 64'd3);
    rd(6'h18, 32'h0000_0007, "rd ctrl cleared");

    // Shadow write coincident with commit copy: old value copied
    wr(6'h04, 32'h000A_0014, 2'b10);
    wr(6'h18, 32'h0000_000B, 2'b10);
    vb_wr(6'h04, 32'h0007_0009);
    check("coincide x1", 64'(spr1_x), 64'd20);
    check("coincide y1", 64'(spr1_y), 64'd10);
    rd(6'h04, 32'h0007_0009, "rd pos1 new");

    // Unmapped addresses
    wr(6'h20, 32'hFFFF_FFFF, 2'b10);
    rd(6'h20, 32'h0, "rd unmapped 0x20");
    rd(6'h3C, 32'h0, "rd unmapped 0x3C");
    rd(6'h00, 32'h0064_0032, "rd pos0 after unmapped");

    // Back-to-back requests give one strobe per two cycles
    @(negedge clk);
    address = 6'h00; data_read_n = 2'b00;
    @(negedge clk);
    check("b2b ready1", 64'(data_ready), 64'd1);
    check("b2b data1", 64'(data_out), 64'h0064_0032);
    @(negedge clk);
    check("b2b ready0", 64'(data_ready), 64'd0);
    check("b2b data0", 64'(data_out), 64'd0);
    @(negedge clk);
    check("b2b ready2", 64'(data_ready), 64'd1);
    @(negedge clk);
    check("b2b ready0b", 64'(data_ready), 64'd0);
    data_read_n = 2'b11;

    // Frame register
    wr(6'h1C, 32'hFFFF_FFFF, 2'b10);
    vb(); vb(); vb();
`ifdef SPRITE_REGS_FRAME_CNT_EN
    rd(6'h1C, 32'(nvb % 65536), "rd frame count");
    @(negedge clk);
    vblank_start = 1'b1;
    repeat (65536) @(negedge clk);
    vblank_start = 1'b0;
    rd(6'h1C, 32'(nvb % 65536), "rd frame wrap");
`else
    rd(6'h1C, 32'h0, "rd frame absent");
`endif

    // Reset abandons pending commit and in-flight read
    wr(6'h00, 32'h0001_0001, 2'b10);
    wr(6'h18, 32'h0000_0009, 2'b10);
    @(negedge clk);
    address = 6'h00; data_read_n = 2'b00; rst_n = 1'b0;
    @(negedge clk);
    data_read_n = 2'b11;
    check("rst read ready", 64'(data_ready), 64'd0);
    check("rst read data", 64'(data_out), 64'd0);
    check("rst active x0", 64'(spr0_x), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post rst ready", 64'(data_ready), 64'd0);
    vb();
    check("post rst enable", 64'(spr_enable), 64'd0);
    check("post rst bmp0", spr0_bitmap, 64'd0);
    rd(6'h18, 32'h0, "rd ctrl after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
